// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider feeding the HI/LO registers
//
// Computes one quotient bit per cycle on operand magnitudes, then applies the
// sign fix-up. Divide-by-zero skips the iteration and returns all-ones / dividend.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start_i     divide request, held by execute stage while busy_o is high
//   signed_i    1 = DIV (two's complement), 0 = DIVU; sampled with start_i
//   cancel_i    abort (pipeline flush); wins over start_i in every state
//   a_i, b_i    dividend / divisor; sampled with start_i
//   busy_o      stall request, combinational from start_i in the request cycle
//   valid_o     one-cycle result strobe (HI/LO write enable)
//   quotient_o  registered quotient (LO)
//   remainder_o registered remainder (HI)
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;

  stateT state, nextState;

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dvdReg;   // dividend magnitude, shifted out; quotient bits shift in
  logic [WIDTH-1:0] dvsReg;   // divisor magnitude
  logic [WIDTH-1:0] remReg;   // partial remainder
  logic             negQ;
  logic             negR;

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign absA = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign absB = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // remReg < dvsReg always holds, so shifted < 2*dvsReg and a successful
  // subtraction never sets bit WIDTH; that bit is therefore a clean borrow flag.
  assign shifted = {remReg, dvdReg[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsReg};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    if (cancel_i) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i) nextState = (b_i == '0) ? DONE : CALC;
        CALC:    if (count == CNT_W'(1)) nextState = FIX;
        FIX:     nextState = DONE;
        DONE:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; busy_o also reacts to the request itself
  always_comb begin
    busy_o  = 1'b0;
    valid_o = 1'b0;
    if (!rst) begin
      busy_o  = ((state == IDLE) && start_i && !cancel_i) || (state == CALC) || (state == FIX);
      valid_o = (state == DONE) && !cancel_i;
    end
  end

  // Datapath; a cancel freezes everything so nothing is committed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      dvdReg      <= '0;
      dvsReg      <= '0;
      remReg      <= '0;
      negQ        <= 1'b0;
      negR        <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else if (!cancel_i) begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (b_i != '0) begin
              dvdReg <= absA;
              dvsReg <= absB;
              remReg <= '0;
              count  <= CNT_W'(WIDTH);
              negQ   <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              negR   <= signed_i && a_i[WIDTH-1];
            end else begin
              quotient_o  <= '1;
              remainder_o <= a_i;
            end
          end
        end
        CALC: begin
          remReg <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          dvdReg <= {dvdReg[WIDTH-2:0], ~trial[WIDTH]};
          count  <= count - CNT_W'(1);
        end
        FIX: begin
          quotient_o  <= negQ ? -dvdReg : dvdReg;
          remainder_o <= negR ? -remReg : remReg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit at WIDTH=32 and WIDTH=8
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start32, sgn32, cancel32, busy32, valid32;
  logic [31:0] a32, b32, q32, r32;
  logic        start8, sgn8, cancel8, busy8, valid8;
  logic [7:0]  a8, b8, q8, r8;

  div_unit #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start_i(start32), .signed_i(sgn32), .cancel_i(cancel32),
    .a_i(a32), .b_i(b32), .busy_o(busy32), .valid_o(valid32),
    .quotient_o(q32), .remainder_o(r32)
  );

  div_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start_i(start8), .signed_i(sgn8), .cancel_i(cancel8),
    .a_i(a8), .b_i(b8), .busy_o(busy8), .valid_o(valid8),
    .quotient_o(q8), .remainder_o(r8)
  );

  int nPass  = 0;
  int nTotal = 0;

  logic [63:0] exp32[$];
  logic [15:0] exp8[$];
  logic [31:0] lastQ, lastR;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    nTotal++;
    if (act === expv) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  // Reference: plain integer arithmetic (truncating division, remainder takes
  // the dividend's sign), then wrapped to w bits.
  function automatic void model(input int w, input bit s, input longint unsigned a,
                                input longint unsigned b,
                                output longint unsigned q, output longint unsigned r);
    longint unsigned mask;
    longint sa, sb;
    mask = (longint'(1) << w) - 1;
    if (b == 0) begin
      q = mask;
      r = a;
    end else if (s) begin
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      q = longint'(sa / sb) & mask;
      r = longint'(sa % sb) & mask;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Monitors: pop an expectation for every result strobe
  always @(negedge clk) begin
    logic [63:0] e;
    #1;
    if (valid32) begin
      if (exp32.size() == 0) begin
        nTotal++;
        $display("FAIL valid32_unexpected: valid_o=1 with no pending request, expected 0");
      end else begin
        e = exp32.pop_front();
        check("q32", 64'(q32), 64'(e[63:32]));
        check("r32", 64'(r32), 64'(e[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    #1;
    if (valid8) begin
      if (exp8.size() == 0) begin
        nTotal++;
        $display("FAIL valid8_unexpected: valid_o=1 with no pending request, expected 0");
      end else begin
        e = exp8.pop_front();
        check("q8", 64'(q8), 64'(e[15:8]));
        check("r8", 64'(r8), 64'(e[7:0]));
      end
    end
  end

  // Issue one request, hold start while stalled, measure busy/valid timing
  task automatic run32(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint unsigned mq, mr;
    int cyc, busyCnt, validCyc, lat;
    cyc = 0; busyCnt = 0; validCyc = -1;
    model(32, s, 64'(a), 64'(b), mq, mr);
    lat = (b == 0) ? 1 : 34;
    sgn32 = s; a32 = a; b32 = b; start32 = 1'b1;
    exp32.push_back({mq[31:0], mr[31:0]});
    while (validCyc < 0 && cyc < 200) begin
      #1;
      if (busy32) busyCnt++;
      if (valid32) validCyc = cyc;
      if (!busy32) start32 = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start32 = 1'b0;
    check("latency32", 64'(validCyc), 64'(lat));
    check("busycycles32", 64'(busyCnt), 64'(lat));
    #1 check("pulse32", 64'(valid32), 64'(0));
    lastQ = mq[31:0];
    lastR = mr[31:0];
  endtask

  task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b);
    longint unsigned mq, mr;
    int cyc, validCyc, lat;
    cyc = 0; validCyc = -1;
    model(8, s, 64'(a), 64'(b), mq, mr);
    lat = (b == 0) ? 1 : 10;
    sgn8 = s; a8 = a; b8 = b; start8 = 1'b1;
    exp8.push_back({mq[7:0], mr[7:0]});
    while (validCyc < 0 && cyc < 100) begin
      #1;
      if (valid8) validCyc = cyc;
      if (!busy8) start8 = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    check("latency8", 64'(validCyc), 64'(lat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  ra8, rb8;

    rst = 1'b1;
    start32 = 1'b1; sgn32 = 1'b0; cancel32 = 1'b0; a32 = 32'd100; b32 = 32'd7;
    start8 = 1'b0; sgn8 = 1'b0; cancel8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", 64'(busy32), 64'(0));
    check("reset_valid", 64'(valid32), 64'(0));
    check("reset_q", 64'(q32), 64'(0));
    check("reset_r", 64'(r32), 64'(0));
    start32 = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, issued back-to-back
    run32(1'b0, 32'd100, 32'd7);
    run32(1'b1, 32'hFFFFFFF9, 32'd2);
    run32(1'b1, 32'd7, 32'hFFFFFFFE);
    run32(1'b1, 32'h80000000, 32'hFFFFFFFF);
    run32(1'b0, 32'h80000000, 32'hFFFFFFFF);
    run32(1'b0, 32'd5, 32'd0);
    run32(1'b1, 32'hFFFFFFFB, 32'd0);

    // Random operands with a mix of divisor magnitudes and zero
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'd0 - 32'($urandom_range(1, 15));
        default: rb = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & 32'h0000FFFF);
      endcase
      run32(1'($urandom_range(0, 1)), ra, rb);
    end

    // Cancel mid-CALC: no result, outputs held, next request normal
    @(negedge clk);
    sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    repeat (10) @(negedge clk);
    cancel32 = 1'b1; start32 = 1'b0;
    @(negedge clk);
    cancel32 = 1'b0;
    #1;
    check("cancel_idle_busy", 64'(busy32), 64'(0));
    check("cancel_hold_q", 64'(q32), 64'(lastQ));
    check("cancel_hold_r", 64'(r32), 64'(lastR));
    run32(1'b0, 32'd9, 32'd4);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_q", 64'(q32), 64'(0));
    check("rst_r", 64'(r32), 64'(0));
    check("rst_busy", 64'(busy32), 64'(0));
    check("rst_valid", 64'(valid32), 64'(0));
    start32 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run32(1'b0, 32'd9, 32'd4);

    // Cancel during FIX: results must not be committed
    @(negedge clk);
    sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    repeat (33) @(negedge clk);
    cancel32 = 1'b1; start32 = 1'b0;
    @(negedge clk);
    cancel32 = 1'b0;
    #1;
    check("cancelfix_q", 64'(q32), 64'(lastQ));
    check("cancelfix_r", 64'(r32), 64'(lastR));

    // Cancel together with start: nothing happens
    @(negedge clk);
    a32 = 32'd100; b32 = 32'd7; start32 = 1'b1; cancel32 = 1'b1;
    #1 check("startcancel_busy", 64'(busy32), 64'(0));
    @(negedge clk);
    start32 = 1'b0; cancel32 = 1'b0;
    #1 check("startcancel_idle", 64'(busy32), 64'(0));
    repeat (40) @(negedge clk);
    check("startcancel_hold_q", 64'(q32), 64'(lastQ));

    // WIDTH=8 instance
    run8(1'b0, 8'd200, 8'd3);
    run8(1'b1, 8'h80, 8'hFF);
    run8(1'b1, 8'hF9, 8'd2);
    run8(1'b0, 8'd5, 8'd0);
    for (int i = 0; i < 60; i++) begin
      ra8 = 8'($urandom);
      rb8 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run8(1'($urandom_range(0, 1)), ra8, rb8);
    end

    repeat (3) @(negedge clk);
    check("drain32", 64'(exp32.size()), 64'(0));
    check("drain8", 64'(exp8.size()), 64'(0));

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
